// File: rtl/heap_array_allocator_if.sv
// ---------------------------------------------------------------------------
// heap_array_allocator_if
//   Request/response bundle for heap_array_allocator.
//
//   Signals (master = requester, slave = allocator):
//     allocReq    m->s  request a new array handle
//     allocAck    s->m  one-cycle grant pulse, allocIdx valid
//     allocIdx    s->m  granted handle, held until the next grant
//     allocFail   s->m  one-cycle pulse, no handle available
//     freeReq     m->s  return handle freeIdx
//     freeIdx     m->s  handle being returned
//     freeAck     s->m  one-cycle pulse, free accepted
//     sizeClr     s->m  one-cycle pulse alongside allocAck
//     sizeClrIdx  s->m  size entry to clear (equals allocIdx)
//     allocs      s->m  high-water mark of counter-issued handles
//     freedTop    s->m  current freed-stack depth
//     freeErr     s->m  (only with ALLOC_DOUBLE_FREE_CHECK_EN) bad free
// ---------------------------------------------------------------------------
interface heap_array_allocator_if #(
  parameter int MemoryElementWidth = 12
) ();
  logic                          allocReq;
  logic                          allocAck;
  logic [MemoryElementWidth-1:0] allocIdx;
  logic                          allocFail;
  logic                          freeReq;
  logic [MemoryElementWidth-1:0] freeIdx;
  logic                          freeAck;
  logic                          sizeClr;
  logic [MemoryElementWidth-1:0] sizeClrIdx;
  logic [MemoryElementWidth-1:0] allocs;
  logic [MemoryElementWidth-1:0] freedTop;
`ifdef ALLOC_DOUBLE_FREE_CHECK_EN
  logic                          freeErr;
`endif

  modport master (
    output allocReq, freeReq, freeIdx,
    input  allocAck, allocIdx, allocFail, freeAck, sizeClr, sizeClrIdx,
           allocs, freedTop
`ifdef ALLOC_DOUBLE_FREE_CHECK_EN
    , input freeErr
`endif
  );

  modport slave (
    input  allocReq, freeReq, freeIdx,
    output allocAck, allocIdx, allocFail, freeAck, sizeClr, sizeClrIdx,
           allocs, freedTop
`ifdef ALLOC_DOUBLE_FREE_CHECK_EN
    , output freeErr
`endif
  );
endinterface

// File: rtl/heap_array_allocator.sv
// ---------------------------------------------------------------------------
// heap_array_allocator
//   Hands out array handles 0..NArrays-1. Returned handles go onto a LIFO
//   freed stack and are reused before fresh handles are taken from the
//   high-water counter. All responses are registered (one-cycle latency).
//
//   Ports:
//     clock  single clock, rising edge
//     reset  synchronous, active-high
//     bus    heap_array_allocator_if.slave (see interface for members)
//
//   Build option:
//     ALLOC_DOUBLE_FREE_CHECK_EN  adds an in-use map and bus.freeErr; frees
//     of never-issued or already-free handles are rejected with freeErr.
// ---------------------------------------------------------------------------
module heap_array_allocator #(
  parameter int NArrays            = 20,
  parameter int MemoryElementWidth = 12
) (
  input logic                   clock,
  input logic                   reset,
  heap_array_allocator_if.slave bus
);
  localparam int              MW    = MemoryElementWidth;
  localparam int              AW    = (NArrays > 1) ? $clog2(NArrays) : 1;
  localparam logic [MW-1:0]   LIMIT = MW'(NArrays);
  localparam logic [MW-1:0]   ONE   = MW'(1);

  logic [MW-1:0] freed_q [NArrays];

  logic [MW-1:0] allocs_q,    allocs_d;
  logic [MW-1:0] freed_top_q, freed_top_d;
  logic [MW-1:0] alloc_idx_q, alloc_idx_d;
  logic          alloc_ack_q, alloc_ack_d;
  logic          alloc_fail_q, alloc_fail_d;
  logic          free_ack_q,  free_ack_d;

  logic          push_en;
  logic [AW-1:0] push_ptr;
  logic [AW-1:0] pop_ptr;
  logic [MW-1:0] top_after_pop;
  logic          free_valid;

`ifdef ALLOC_DOUBLE_FREE_CHECK_EN
  logic [NArrays-1:0] in_use_q, in_use_d;
  logic               free_err_q, free_err_d;

  // A handle may only be returned if it was issued and is currently out.
  assign free_valid = (bus.freeIdx < allocs_q) && in_use_q[bus.freeIdx[AW-1:0]];
`else
  assign free_valid = 1'b1;
`endif

  assign pop_ptr = AW'(freed_top_q - ONE);

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    allocs_d      = allocs_q;
    alloc_idx_d   = alloc_idx_q;
    alloc_ack_d   = 1'b0;
    alloc_fail_d  = 1'b0;
    free_ack_d    = 1'b0;
    push_en       = 1'b0;
    push_ptr      = '0;
    top_after_pop = freed_top_q;
`ifdef ALLOC_DOUBLE_FREE_CHECK_EN
    free_err_d    = 1'b0;
    in_use_d      = in_use_q;
`endif

    // Allocation is decided purely from pre-edge state: reuse the most
    // recently freed handle, else take a fresh one from the counter.
    if (bus.allocReq) begin
      if (freed_top_q != '0) begin
        alloc_idx_d   = freed_q[pop_ptr];
        top_after_pop = freed_top_q - ONE;
        alloc_ack_d   = 1'b1;
      end else if (allocs_q != LIMIT) begin
        alloc_idx_d   = allocs_q;
        allocs_d      = allocs_q + ONE;
        alloc_ack_d   = 1'b1;
      end else begin
        alloc_fail_d  = 1'b1;
      end
    end

    freed_top_d = top_after_pop;

    // The free pushes on top of whatever the alloc left, so a same-cycle
    // pop+push keeps the depth and freeIdx becomes the new top; it is never
    // forwarded to allocIdx.
    if (bus.freeReq) begin
      if (free_valid) begin
        free_ack_d = 1'b1;
        if (top_after_pop != LIMIT) begin
          push_en     = 1'b1;
          push_ptr    = top_after_pop[AW-1:0];
          freed_top_d = top_after_pop + ONE;
        end
`ifdef ALLOC_DOUBLE_FREE_CHECK_EN
        in_use_d[bus.freeIdx[AW-1:0]] = 1'b0;
`endif
      end else begin
`ifdef ALLOC_DOUBLE_FREE_CHECK_EN
        free_err_d = 1'b1;
`endif
      end
    end

`ifdef ALLOC_DOUBLE_FREE_CHECK_EN
    if (alloc_ack_d) begin
      in_use_d[alloc_idx_d[AW-1:0]] = 1'b1;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      allocs_q     <= '0;
      freed_top_q  <= '0;
      alloc_idx_q  <= '0;
      alloc_ack_q  <= 1'b0;
      alloc_fail_q <= 1'b0;
      free_ack_q   <= 1'b0;
`ifdef ALLOC_DOUBLE_FREE_CHECK_EN
      in_use_q     <= '0;
      free_err_q   <= 1'b0;
`endif
    end else begin
      allocs_q     <= allocs_d;
      freed_top_q  <= freed_top_d;
      alloc_idx_q  <= alloc_idx_d;
      alloc_ack_q  <= alloc_ack_d;
      alloc_fail_q <= alloc_fail_d;
      free_ack_q   <= free_ack_d;
`ifdef ALLOC_DOUBLE_FREE_CHECK_EN
      in_use_q     <= in_use_d;
      free_err_q   <= free_err_d;
`endif
    end
  end

  // NOTE: the stack storage is not reset; entries at or above freedTop are
  // never read, so clearing them would only cost reset fan-out.
  always_ff @(posedge clock) begin
    if (push_en && !reset) begin
      freed_q[push_ptr] <= bus.freeIdx;
    end
  end

  assign bus.allocAck   = alloc_ack_q;
  assign bus.allocIdx   = alloc_idx_q;
  assign bus.allocFail  = alloc_fail_q;
  assign bus.freeAck    = free_ack_q;
  assign bus.sizeClr    = alloc_ack_q;
  assign bus.sizeClrIdx = alloc_idx_q;
  assign bus.allocs     = allocs_q;
  assign bus.freedTop   = freed_top_q;
`ifdef ALLOC_DOUBLE_FREE_CHECK_EN
  assign bus.freeErr    = free_err_q;
`endif

endmodule

// File: tb/tb_heap_array_allocator.sv
// ---------------------------------------------------------------------------
// tb_heap_array_allocator
//   Directed scenarios followed by randomized traffic, all compared each
//   cycle against a queue-based reference model of the allocator.
//   Honours ALLOC_DOUBLE_FREE_CHECK_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_heap_array_allocator;
  localparam int NARR = 20;
  localparam int MW   = 12;

  logic clock = 1'b0;
  logic reset = 1'b1;

  heap_array_allocator_if #(.MemoryElementWidth(MW)) bus ();

  heap_array_allocator #(
    .NArrays            (NARR),
    .MemoryElementWidth (MW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: stack as a queue (back = top), plain counters.
  int m_stack[$];
  int m_allocs = 0;
  int m_idx    = 0;
  bit m_in_use [NARR];
  bit e_aa, e_af, e_fa, e_fe;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit a, input bit f, input int fi, input bit r);
    int  allocs_pre;
    bit  ok;
    e_aa = 0; e_af = 0; e_fa = 0; e_fe = 0;
    if (r) begin
      m_stack.delete();
      m_allocs = 0;
      m_idx    = 0;
      foreach (m_in_use[i]) m_in_use[i] = 0;
    end else begin
      allocs_pre = m_allocs;
      ok = 1;
`ifdef ALLOC_DOUBLE_FREE_CHECK_EN
      ok = (fi < allocs_pre) ? m_in_use[fi] : 1'b0;
`endif
      if (a) begin
        if (m_stack.size() > 0) begin
          m_idx = m_stack.pop_back();
          e_aa  = 1;
        end else if (m_allocs < NARR) begin
          m_idx = m_allocs;
          m_allocs++;
          e_aa  = 1;
        end else begin
          e_af  = 1;
        end
        if (e_aa) m_in_use[m_idx] = 1;
      end
      if (f) begin
        if (ok) begin
          e_fa = 1;
          if (m_stack.size() < NARR) m_stack.push_back(fi);
          if (fi < NARR) m_in_use[fi] = 0;
        end else begin
          e_fe = 1;
        end
      end
    end
  endtask

  // One clock: drive, let the edge happen, then compare registered outputs.
  task automatic step(input bit a, input bit f, input int fi, input bit r);
    bus.allocReq = a;
    bus.freeReq  = f;
    bus.freeIdx  = MW'(fi);
    reset        = r;
    @(posedge clock);
    #1;
    model_step(a, f, fi, r);
    bus.allocReq = 1'b0;
    bus.freeReq  = 1'b0;
    reset        = 1'b0;
    check("allocAck",   32'(bus.allocAck),   32'(e_aa));
    check("allocFail",  32'(bus.allocFail),  32'(e_af));
    check("allocIdx",   32'(bus.allocIdx),   32'(m_idx));
    check("sizeClr",    32'(bus.sizeClr),    32'(e_aa));
    check("sizeClrIdx", 32'(bus.sizeClrIdx), 32'(m_idx));
    check("freeAck",    32'(bus.freeAck),    32'(e_fa));
    check("allocs",     32'(bus.allocs),     32'(m_allocs));
    check("freedTop",   32'(bus.freedTop),   32'(m_stack.size()));
`ifdef ALLOC_DOUBLE_FREE_CHECK_EN
    check("freeErr",    32'(bus.freeErr),    32'(e_fe));
`endif
  endtask

  initial begin
    bus.allocReq = 1'b0;
    bus.freeReq  = 1'b0;
    bus.freeIdx  = '0;

    // Reset, then three fresh handles 0,1,2.
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    repeat (3) step(1, 0, 0, 0);
    // Free 1 then 2; allocs come back LIFO as 2 then 1.
    step(0, 1, 1, 0);
    step(0, 1, 2, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    // Double free of 4 and free of an unissued handle.
    repeat (2) step(1, 0, 0, 0);
    step(0, 1, 4, 0);
    step(0, 1, 4, 0);
    step(0, 1, 15, 0);

    // Stack depth 1 with top 5, then same-cycle alloc and free 7.
    step(0, 0, 0, 1);
    repeat (6) step(1, 0, 0, 0);
    step(0, 1, 5, 0);
    step(1, 1, 7, 0);
    step(1, 0, 0, 0);

    // Exhaust the counter, refuse the 21st, then overfill the stack.
    step(0, 0, 0, 1);
    repeat (NARR) step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < NARR; i++) step(0, 1, i, 0);
    step(0, 1, 3, 0);
    step(1, 1, 9, 0);

    // Reset wins over a same-cycle alloc; counting restarts at 0.
    step(0, 0, 0, 1);
    repeat (5) step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    step(1, 0, 0, 0);

    // Randomized phases: alloc-heavy, free-heavy, balanced, with rare resets.
    for (int ph = 0; ph < 6; ph++) begin
      int pa;
      pa = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 25 : 50;
      for (int k = 0; k < 400; k++) begin
        bit a, f, r;
        int fi;
        a = ($urandom_range(0, 99) < pa);
        f = ($urandom_range(0, 99) < (100 - pa));
        r = ($urandom_range(0, 299) == 0);
        if ($urandom_range(0, 3) == 0 || m_allocs == 0)
          fi = $urandom_range(0, NARR + 3);
        else
          fi = $urandom_range(0, m_allocs - 1);
        step(a, f, fi, r);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
